// File: rtl/alu_pkg.sv
// Shared ALU encodings for the EX stage: ALU-op classes from main control and
// ALU control codes, which reuse the MIPS32 funct encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    ALUOP_ADD    = 3'b000,
    ALUOP_BRANCH = 3'b001,
    ALUOP_AND    = 3'b010,
    ALUOP_OR     = 3'b011,
    ALUOP_XOR    = 3'b100,
    ALUOP_SLT    = 3'b101,
    ALUOP_RTYPE  = 3'b110,
    ALUOP_JUMP   = 3'b111
  } aluop_e;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SC_B = 6'b001001;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage

// File: rtl/funct_legal_chk.sv
// Combinational lookup: is the R-type funct field one the ALU implements?
module funct_legal_chk
  import alu_pkg::*;
#(
  parameter int unsigned ALU_FUNCT_BUS_WIDTH = 6
) (
  input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
  output logic                           o_legal
);

  always_comb begin
    o_legal = 1'b0;
    case (i_funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV,
      FUNCT_JR, FUNCT_JALR,
      FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
      FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
      FUNCT_SLT, FUNCT_SLTU: o_legal = 1'b1;
      default:               o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// EX-stage ALU control decoder with registered copy for EX/MEM.
// Optional illegal-funct trap enabled by macro ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_BUS_WIDTH  = 6,
  parameter int unsigned ALU_OP_BUS_WIDTH    = 3,
  parameter int unsigned ALU_FUNCT_BUS_WIDTH = 6
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
  input  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_opp,
  output logic [ALU_CTRL_BUS_WIDTH-1:0]  o_alu_ctrl,
  output logic [ALU_CTRL_BUS_WIDTH-1:0]  o_alu_ctrl_q,
  output logic                           o_illegal,
  output logic                           o_illegal_sticky
);

  logic [ALU_CTRL_BUS_WIDTH-1:0] alu_ctrl;
  logic [ALU_CTRL_BUS_WIDTH-1:0] alu_ctrl_d, alu_ctrl_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic funct_legal;
  logic illegal;
  logic illegal_sticky_d, illegal_sticky_q;

  funct_legal_chk #(
    .ALU_FUNCT_BUS_WIDTH(ALU_FUNCT_BUS_WIDTH)
  ) u_funct_legal_chk (
    .i_funct(i_funct),
    .o_legal(funct_legal)
  );

  always_comb begin
    illegal = (i_alu_opp == ALUOP_RTYPE) && !funct_legal;
  end
`endif

  // Funct only appears in the R-type arm so X on i_funct cannot leak elsewhere.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (i_alu_opp)
      ALUOP_ADD:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_AND:    alu_ctrl = ALU_AND;
      ALUOP_OR:     alu_ctrl = ALU_OR;
      ALUOP_XOR:    alu_ctrl = ALU_XOR;
      ALUOP_SLT:    alu_ctrl = ALU_SLT;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      ALUOP_RTYPE:  alu_ctrl = funct_legal ? i_funct : ALU_ADD;
`else
      ALUOP_RTYPE:  alu_ctrl = i_funct;
`endif
      ALUOP_JUMP:   alu_ctrl = ALU_SC_B;
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_ctrl_d = alu_ctrl_q;
    if (i_en) begin
      alu_ctrl_d = alu_ctrl;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_ctrl_q <= '0;
    end else begin
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  always_comb begin
    illegal_sticky_d = illegal_sticky_q;
    if (i_en && illegal) begin
      illegal_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_sticky_q <= 1'b0;
    end else begin
      illegal_sticky_q <= illegal_sticky_d;
    end
  end

  always_comb begin
    o_illegal        = illegal;
    o_illegal_sticky = illegal_sticky_q;
  end
`else
  always_comb begin
    o_illegal        = 1'b0;
    o_illegal_sticky = 1'b0;
  end
`endif

  always_comb begin
    o_alu_ctrl   = alu_ctrl;
    o_alu_ctrl_q = alu_ctrl_q;
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl; expectations follow
// ALU_CTRL_ILLEGAL_TRAP_EN when the bench is built with that macro.
module tb_alu_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [5:0] funct;
  logic [2:0] opp;
  logic [5:0] alu_ctrl;
  logic [5:0] alu_ctrl_q;
  logic       illegal;
  logic       illegal_sticky;

  int unsigned n_pass;
  int unsigned n_total;

  alu_ctrl #(
    .ALU_CTRL_BUS_WIDTH (6),
    .ALU_OP_BUS_WIDTH   (3),
    .ALU_FUNCT_BUS_WIDTH(6)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (en),
    .i_funct         (funct),
    .i_alu_opp       (opp),
    .o_alu_ctrl      (alu_ctrl),
    .o_alu_ctrl_q    (alu_ctrl_q),
    .o_illegal       (illegal),
    .o_illegal_sticky(illegal_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Supported R-type functs.
  logic [5:0] legal_tab [18] = '{
    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
    6'b001000, 6'b001001, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
    6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011
  };
  logic [2:0] imm_opp [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
  logic [5:0] imm_exp [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b101010, 6'b001001};

  logic       exp_ill;
  logic [5:0] exp_ctrl_bad;

  initial begin
    n_pass  = 0;
    n_total = 0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    exp_ill      = 1'b1;
    exp_ctrl_bad = 6'b100000;
`else
    exp_ill      = 1'b0;
    exp_ctrl_bad = 6'b111111;
`endif

    rst_n = 1'b0;
    en    = 1'b0;
    opp   = 3'b110;
    funct = 6'b111111;
    #12;
    check("reset_q", alu_ctrl_q, 6'b000000);
    check("reset_sticky", {5'b0, illegal_sticky}, 6'b0);
    rst_n = 1'b1;
    tick();

    // R-type AND, then registered.
    en    = 1'b1;
    opp   = 3'b110;
    funct = 6'b100100;
    #1;
    check("rtype_and_ctrl", alu_ctrl, 6'b100100);
    check("rtype_and_ill", {5'b0, illegal}, 6'b0);
    tick();
    check("rtype_and_q", alu_ctrl_q, 6'b100100);

    // Immediate classes ignore funct (driven X).
    funct = 6'bxxxxxx;
    for (int i = 0; i < 7; i++) begin
      opp = imm_opp[i];
      #1;
      check($sformatf("imm_opp_%b", imm_opp[i]), alu_ctrl, imm_exp[i]);
    end

    // Stall holds registered value.
    funct = 6'b000000;
    opp   = 3'b000;
    en    = 1'b1;
    tick();
    check("load_add_q", alu_ctrl_q, 6'b100000);
    en  = 1'b0;
    opp = 3'b101;
    tick();
    check("stall_comb", alu_ctrl, 6'b101010);
    check("stall_hold_q", alu_ctrl_q, 6'b100000);
    tick();
    check("stall_hold_q2", alu_ctrl_q, 6'b100000);

    // Illegal funct; stalled edge must not set sticky.
    opp   = 3'b110;
    funct = 6'b111111;
    en    = 1'b0;
    #1;
    check("illegal_ctrl", alu_ctrl, exp_ctrl_bad);
    check("illegal_flag", {5'b0, illegal}, {5'b0, exp_ill});
    tick();
    check("sticky_stalled", {5'b0, illegal_sticky}, 6'b0);
    en = 1'b1;
    tick();
    check("sticky_set", {5'b0, illegal_sticky}, {5'b0, exp_ill});
    check("illegal_q", alu_ctrl_q, exp_ctrl_bad);
    funct = 6'b100000;
    tick();
    check("legal_after_ill", {5'b0, illegal}, 6'b0);
    check("sticky_holds", {5'b0, illegal_sticky}, {5'b0, exp_ill});

    // Asynchronous reset between edges.
    opp = 3'b111;
    tick();
    check("pre_rst_q", alu_ctrl_q, 6'b001001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", alu_ctrl_q, 6'b000000);
    check("async_rst_sticky", {5'b0, illegal_sticky}, 6'b0);
    check("rst_comb_unaffected", alu_ctrl, 6'b001001);
    #3;
    rst_n = 1'b1;
    tick();

    // Supported funct sweep.
    opp = 3'b110;
    for (int i = 0; i < 18; i++) begin
      funct = legal_tab[i];
      #1;
      check($sformatf("sweep_ctrl_%b", legal_tab[i]), alu_ctrl, legal_tab[i]);
      check($sformatf("sweep_ill_%b", legal_tab[i]), {5'b0, illegal}, 6'b0);
    end

    // Unsupported functs adjacent to supported ones.
    funct = 6'b000001;
    #1;
    check("unsup_000001_ctrl", alu_ctrl, exp_ill ? 6'b100000 : 6'b000001);
    check("unsup_000001_ill", {5'b0, illegal}, {5'b0, exp_ill});
    funct = 6'b101100;
    #1;
    check("unsup_101100_ctrl", alu_ctrl, exp_ill ? 6'b100000 : 6'b101100);
    check("unsup_101100_ill", {5'b0, illegal}, {5'b0, exp_ill});
    opp = 3'b000;
    #1;
    check("nonrtype_no_ill", {5'b0, illegal}, 6'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- ALU control decoder in the EX stage of the 5-stage MIPS32 pipeline.
- Maps the 3-bit ALU-op class from the main control unit, plus the R-type funct field, to the 6-bit ALU operation code consumed by the ALU.
- ALU codes reuse MIPS funct encodings.
- Provides a combinational result, a registered copy for the EX/MEM boundary, and optional illegal-funct detection.

Parameters:
- ALU_CTRL_BUS_WIDTH, 6, width of the ALU control output.
- ALU_OP_BUS_WIDTH, 3, width of the ALU-op class input.
- ALU_FUNCT_BUS_WIDTH, 6, width of the instruction funct field.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  register enable for o_alu_ctrl_q; low = stall, hold value.
- i_funct  input  ALU_FUNCT_BUS_WIDTH  instruction bits [5:0]; used only when i_alu_opp = 3'b110.
- i_alu_opp  input  ALU_OP_BUS_WIDTH  ALU-op class from main control.
- o_alu_ctrl  output  ALU_CTRL_BUS_WIDTH  combinational ALU operation code.
- o_alu_ctrl_q  output  ALU_CTRL_BUS_WIDTH  registered o_alu_ctrl.
- o_illegal  output  1  combinational: R-type with unsupported funct.
- o_illegal_sticky  output  1  latched OR of o_illegal since reset.

Behaviour:
- o_alu_ctrl is purely combinational with zero latency. It depends only on i_alu_opp except in the R-type class. X/Z on i_funct must not reach the output in non-R-type classes: use a full case on i_alu_opp with no funct term.
- i_alu_opp decode:
  - 000 (load/store/ADDI) -> 6'b100000 (ADD)
  - 001 (branch BEQ/BNE) -> 6'b100010 (SUB)
  - 010 (ANDI) -> 6'b100100 (AND)
  - 011 (ORI) -> 6'b100101 (OR)
  - 100 (XORI) -> 6'b100110 (XOR)
  - 101 (SLTI) -> 6'b101010 (SLT)
  - 110 (R-type) -> i_funct passed through unchanged, e.g. 100100 -> 100100
  - 111 (jump/link) -> 6'b001001 (SC_B, pass operand B for the link address)
  - All 8 codes are defined. Any X on i_alu_opp yields an output of 6'b100000 via the default branch.
- Supported R-type funct set: SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, JR 001000, JALR 001001, ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011.
- o_illegal = (i_alu_opp == 110) and i_funct not in the supported set. It is 0 for every other class.
- o_alu_ctrl_q:
  - Reset value 6'b000000.
  - On a rising i_clk edge with i_en = 1, loads o_alu_ctrl.
  - With i_en = 0, holds its value.
- o_illegal_sticky:
  - Reset value 0.
  - Set on a rising edge when i_en = 1 and o_illegal = 1.
  - Cleared only by reset.
- Reset asserted mid-operation clears both registers immediately (asynchronously). The combinational output is unaffected by reset.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported R-type funct drives o_alu_ctrl to 6'b100000 (ADD) instead of passing through.
  - o_illegal and o_illegal_sticky behave as above.
- Undefined:
  - R-type funct is always passed through.
  - The funct legality check is not built; o_illegal and o_illegal_sticky are tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU-op class constants (ALUOP_ADD, ALUOP_BRANCH, ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_SLT, ALUOP_RTYPE, ALUOP_JUMP).
  - ALU control/funct constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SC_B, and the full funct list).
- One natural sub-module: funct_legal_chk, a combinational supported-funct lookup, instantiated only under ALU_CTRL_ILLEGAL_TRAP_EN.

Test Plan:
- R-type AND: i_alu_opp=110, i_funct=100100 -> o_alu_ctrl=100100, o_illegal=0; after a clock edge with i_en=1, o_alu_ctrl_q=100100.
- Immediate classes with i_funct=xxxxxx: 000->100000, 001->100010, 010->100100, 011->100101, 100->100110, 101->101010, 111->001001; no X on the output.
- Stall/reset: i_en=0 while i_alu_opp changes 000->101 -> o_alu_ctrl_q holds 100000. Assert i_rst_n=0 between edges -> o_alu_ctrl_q=000000 and o_illegal_sticky=0 immediately.
- Illegal funct with macro defined: i_alu_opp=110, i_funct=111111 -> o_alu_ctrl=100000, o_illegal=1. After one enabled edge, o_illegal_sticky=1; it stays 1 after returning to legal stimulus.
- Illegal funct with macro undefined: i_alu_opp=110, i_funct=111111 -> o_alu_ctrl=111111, o_illegal=0, o_illegal_sticky=0.
- Sweep of all supported R-type functs -> o_alu_ctrl equals i_funct and o_illegal=0 in both builds.
